// File: rtl/tcm_port_arbiter.sv
// Shares the TCM stbuf read/write port pair between the core LSU (CORE) and the debug/DMA loader (DBG).
// Each channel is arbitrated on its own: fixed CORE priority with a DBG starvation override.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef TCM_SIZE
`define TCM_SIZE 4096
`endif

module tcm_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ARB_TCM_SIZE = `TCM_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        core_rd_valid,
  output logic                        core_rd_ready,
  input  logic [`ADDR_WIDTH-1:0]      core_rd_addr,
  input  logic [`SIZE_WIDTH-1:0]      core_rd_size,
  input  logic                        core_wr_valid,
  output logic                        core_wr_ready,
  input  logic [`ADDR_WIDTH-1:0]      core_wr_addr,
  input  logic [`SIZE_WIDTH-1:0]      core_wr_size,
  input  logic [`REG_DATA_WIDTH-1:0]  core_wr_data,
  output logic                        core_rsp_valid,
  input  logic                        dbg_rd_valid,
  output logic                        dbg_rd_ready,
  input  logic [`ADDR_WIDTH-1:0]      dbg_rd_addr,
  input  logic [`SIZE_WIDTH-1:0]      dbg_rd_size,
  input  logic                        dbg_wr_valid,
  output logic                        dbg_wr_ready,
  input  logic [`ADDR_WIDTH-1:0]      dbg_wr_addr,
  input  logic [`SIZE_WIDTH-1:0]      dbg_wr_size,
  input  logic [`REG_DATA_WIDTH-1:0]  dbg_wr_data,
  output logic                        dbg_rsp_valid,
  output logic [`BUS_DATA_WIDTH-1:0]  rsp_data,
  output logic                        err_valid,
  output logic                        err_src,
  output logic                        err_is_wr,
  output logic                        bus_tcm_stbuf_rd,
  output logic [`ADDR_WIDTH-1:0]      bus_tcm_stbuf_read_addr,
  output logic [`SIZE_WIDTH-1:0]      bus_tcm_stbuf_read_size,
  output logic                        bus_tcm_stbuf_wr,
  output logic [`ADDR_WIDTH-1:0]      bus_tcm_stbuf_write_addr,
  output logic [`SIZE_WIDTH-1:0]      bus_tcm_stbuf_write_size,
  output logic [`REG_DATA_WIDTH-1:0]  bus_tcm_stbuf_data,
  input  logic [`BUS_DATA_WIDTH-1:0]  tcm_bus_stbuf_data
);
  localparam int AW = `ADDR_WIDTH;
  localparam int SW = `SIZE_WIDTH;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam logic [AW:0] TCM_LIM = (AW+1)'(ARB_TCM_SIZE);

  // End address is formed one bit wider so an access near the top of the map cannot wrap into range.
  function automatic logic legal(input logic [AW-1:0] a, input logic [SW-1:0] s);
    logic [AW:0] last;
    last = {1'b0, a} + {{(AW+1-SW){1'b0}}, s};
    return (s == SW'(1) || s == SW'(2) || s == SW'(4)) && (last <= TCM_LIM);
  endfunction

  logic [CW-1:0]             rd_starve, wr_starve;
  logic                      rd_dbg_win, rd_core_win, rd_go, rd_ok, rd_err;
  logic                      wr_dbg_win, wr_core_win, wr_go, wr_ok, wr_err;
  logic [AW-1:0]             rd_addr_m, wr_addr_m;
  logic [SW-1:0]             rd_size_m, wr_size_m;
  logic [`REG_DATA_WIDTH-1:0] wr_data_m;
  logic                      owner_v, owner_src;
  logic                      err_v_q, err_src_q, err_wr_q;
  logic                      pend_v, pend_src;

  assign rd_dbg_win  = !rst && dbg_rd_valid && (!core_rd_valid || rd_starve == LIM);
  assign rd_core_win = !rst && core_rd_valid && !rd_dbg_win;
  assign rd_go       = rd_dbg_win || rd_core_win;
  assign rd_addr_m   = rd_dbg_win ? dbg_rd_addr : core_rd_addr;
  assign rd_size_m   = rd_dbg_win ? dbg_rd_size : core_rd_size;
  assign rd_ok       = legal(rd_addr_m, rd_size_m);
  assign rd_err      = rd_go && !rd_ok;

  assign wr_dbg_win  = !rst && dbg_wr_valid && (!core_wr_valid || wr_starve == LIM);
  assign wr_core_win = !rst && core_wr_valid && !wr_dbg_win;
  assign wr_go       = wr_dbg_win || wr_core_win;
  assign wr_addr_m   = wr_dbg_win ? dbg_wr_addr : core_wr_addr;
  assign wr_size_m   = wr_dbg_win ? dbg_wr_size : core_wr_size;
  assign wr_data_m   = wr_dbg_win ? dbg_wr_data : core_wr_data;
  assign wr_ok       = legal(wr_addr_m, wr_size_m);
  assign wr_err      = wr_go && !wr_ok;

  assign core_rd_ready = rd_core_win;
  assign dbg_rd_ready  = rd_dbg_win;
  assign core_wr_ready = wr_core_win;
  assign dbg_wr_ready  = wr_dbg_win;

  assign bus_tcm_stbuf_rd         = rd_go && rd_ok;
  assign bus_tcm_stbuf_read_addr  = bus_tcm_stbuf_rd ? rd_addr_m : '0;
  assign bus_tcm_stbuf_read_size  = bus_tcm_stbuf_rd ? rd_size_m : '0;
  assign bus_tcm_stbuf_wr         = wr_go && wr_ok;
  assign bus_tcm_stbuf_write_addr = bus_tcm_stbuf_wr ? wr_addr_m : '0;
  assign bus_tcm_stbuf_write_size = bus_tcm_stbuf_wr ? wr_size_m : '0;
  assign bus_tcm_stbuf_data       = bus_tcm_stbuf_wr ? wr_data_m : '0;

  // Masked by rst so a read granted just before reset never returns.
  assign core_rsp_valid = owner_v && !owner_src && !rst;
  assign dbg_rsp_valid  = owner_v && owner_src && !rst;
  assign rsp_data       = (owner_v && !rst) ? tcm_bus_stbuf_data : '0;
  assign err_valid      = err_v_q && !rst;
  assign err_src        = err_src_q;
  assign err_is_wr      = err_wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_starve <= '0;
      wr_starve <= '0;
      owner_v   <= 1'b0;
      owner_src <= 1'b0;
      err_v_q   <= 1'b0;
      err_src_q <= 1'b0;
      err_wr_q  <= 1'b0;
      pend_v    <= 1'b0;
      pend_src  <= 1'b0;
    end else begin
      if (!dbg_rd_valid || rd_dbg_win)  rd_starve <= '0;
      else if (rd_starve != LIM)        rd_starve <= rd_starve + 1'b1;
      if (!dbg_wr_valid || wr_dbg_win)  wr_starve <= '0;
      else if (wr_starve != LIM)        wr_starve <= wr_starve + 1'b1;

      owner_v   <= bus_tcm_stbuf_rd;
      owner_src <= rd_dbg_win;

      // Read error goes first; a coincident write error waits one cycle in the pending slot.
      if (rd_err) begin
        err_v_q   <= 1'b1;
        err_src_q <= rd_dbg_win;
        err_wr_q  <= 1'b0;
        if (wr_err) begin
          pend_v   <= 1'b1;
          pend_src <= wr_dbg_win;
        end
      end else if (pend_v) begin
        err_v_q   <= 1'b1;
        err_src_q <= pend_src;
        err_wr_q  <= 1'b1;
        pend_v    <= wr_err;
        pend_src  <= wr_dbg_win;
      end else if (wr_err) begin
        err_v_q   <= 1'b1;
        err_src_q <= wr_dbg_win;
        err_wr_q  <= 1'b1;
      end else begin
        err_v_q   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: directed scenarios then randomized traffic, all checked against
// a cycle-level reference model of the arbitration, legality, response and error-reporting rules.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef TCM_SIZE
`define TCM_SIZE 4096
`endif

module tb_tcm_port_arbiter;
  localparam int AW = `ADDR_WIDTH;
  localparam int SW = `SIZE_WIDTH;
  localparam int RW = `REG_DATA_WIDTH;
  localparam int BW = `BUS_DATA_WIDTH;
  localparam int LIMIT = 4;
  localparam int TSZ = `TCM_SIZE;

  logic clk, rst;
  logic core_rd_valid, core_rd_ready, core_wr_valid, core_wr_ready, core_rsp_valid;
  logic dbg_rd_valid, dbg_rd_ready, dbg_wr_valid, dbg_wr_ready, dbg_rsp_valid;
  logic [AW-1:0] core_rd_addr, core_wr_addr, dbg_rd_addr, dbg_wr_addr;
  logic [SW-1:0] core_rd_size, core_wr_size, dbg_rd_size, dbg_wr_size;
  logic [RW-1:0] core_wr_data, dbg_wr_data;
  logic [BW-1:0] rsp_data, tcm_bus_stbuf_data;
  logic err_valid, err_src, err_is_wr;
  logic bus_tcm_stbuf_rd, bus_tcm_stbuf_wr;
  logic [AW-1:0] bus_tcm_stbuf_read_addr, bus_tcm_stbuf_write_addr;
  logic [SW-1:0] bus_tcm_stbuf_read_size, bus_tcm_stbuf_write_size;
  logic [RW-1:0] bus_tcm_stbuf_data;

  tcm_port_arbiter #(.STARVE_LIMIT(LIMIT), .ARB_TCM_SIZE(TSZ)) dut (
    .clk(clk), .rst(rst),
    .core_rd_valid(core_rd_valid), .core_rd_ready(core_rd_ready), .core_rd_addr(core_rd_addr), .core_rd_size(core_rd_size),
    .core_wr_valid(core_wr_valid), .core_wr_ready(core_wr_ready), .core_wr_addr(core_wr_addr), .core_wr_size(core_wr_size),
    .core_wr_data(core_wr_data), .core_rsp_valid(core_rsp_valid),
    .dbg_rd_valid(dbg_rd_valid), .dbg_rd_ready(dbg_rd_ready), .dbg_rd_addr(dbg_rd_addr), .dbg_rd_size(dbg_rd_size),
    .dbg_wr_valid(dbg_wr_valid), .dbg_wr_ready(dbg_wr_ready), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_size(dbg_wr_size),
    .dbg_wr_data(dbg_wr_data), .dbg_rsp_valid(dbg_rsp_valid),
    .rsp_data(rsp_data), .err_valid(err_valid), .err_src(err_src), .err_is_wr(err_is_wr),
    .bus_tcm_stbuf_rd(bus_tcm_stbuf_rd), .bus_tcm_stbuf_read_addr(bus_tcm_stbuf_read_addr),
    .bus_tcm_stbuf_read_size(bus_tcm_stbuf_read_size), .bus_tcm_stbuf_wr(bus_tcm_stbuf_wr),
    .bus_tcm_stbuf_write_addr(bus_tcm_stbuf_write_addr), .bus_tcm_stbuf_write_size(bus_tcm_stbuf_write_size),
    .bus_tcm_stbuf_data(bus_tcm_stbuf_data), .tcm_bus_stbuf_data(tcm_bus_stbuf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int src; int is_wr; } err_t;

  int total = 0;
  int bad = 0;
  int starve_rd = 0, starve_wr = 0;
  int rsp_src = -1;
  err_t err_q[$];
  logic g_crd, g_drd, g_cwr, g_dwr;
  logic obs_drd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int a, input int s);
    return (s == 1 || s == 2 || s == 4) && (a + s <= TSZ);
  endfunction

  // 0 = nobody, 1 = CORE, 2 = DBG
  function automatic int winner(input logic c, input logic d, input int losses);
    if (c && d) return (losses >= LIMIT) ? 2 : 1;
    if (c) return 1;
    if (d) return 2;
    return 0;
  endfunction

  task automatic step();
    int rw, ww, ra, rs, wa, ws, wd;
    bit rok, wok;
    err_t e;
    tcm_bus_stbuf_data = BW'($urandom);
    #3;
    obs_drd = dbg_rd_ready;
    if (rst) begin
      chk("rst_core_rd_ready", 64'(core_rd_ready), 64'(0));
      chk("rst_dbg_rd_ready", 64'(dbg_rd_ready), 64'(0));
      chk("rst_core_wr_ready", 64'(core_wr_ready), 64'(0));
      chk("rst_dbg_wr_ready", 64'(dbg_wr_ready), 64'(0));
      chk("rst_rd", 64'(bus_tcm_stbuf_rd), 64'(0));
      chk("rst_wr", 64'(bus_tcm_stbuf_wr), 64'(0));
      chk("rst_core_rsp", 64'(core_rsp_valid), 64'(0));
      chk("rst_dbg_rsp", 64'(dbg_rsp_valid), 64'(0));
      chk("rst_err", 64'(err_valid), 64'(0));
      starve_rd = 0; starve_wr = 0; rsp_src = -1; err_q.delete();
      g_crd = 0; g_drd = 0; g_cwr = 0; g_dwr = 0;
    end else begin
      rw = winner(core_rd_valid, dbg_rd_valid, starve_rd);
      ww = winner(core_wr_valid, dbg_wr_valid, starve_wr);
      ra = int'(rw == 2 ? dbg_rd_addr : core_rd_addr);
      rs = int'(rw == 2 ? dbg_rd_size : core_rd_size);
      wa = int'(ww == 2 ? dbg_wr_addr : core_wr_addr);
      ws = int'(ww == 2 ? dbg_wr_size : core_wr_size);
      wd = int'(ww == 2 ? dbg_wr_data : core_wr_data);
      rok = (rw != 0) && legal(ra, rs);
      wok = (ww != 0) && legal(wa, ws);
      chk("core_rd_ready", 64'(core_rd_ready), 64'(rw == 1));
      chk("dbg_rd_ready", 64'(dbg_rd_ready), 64'(rw == 2));
      chk("core_wr_ready", 64'(core_wr_ready), 64'(ww == 1));
      chk("dbg_wr_ready", 64'(dbg_wr_ready), 64'(ww == 2));
      chk("tcm_rd", 64'(bus_tcm_stbuf_rd), 64'(rok));
      chk("tcm_read_addr", 64'(bus_tcm_stbuf_read_addr), rok ? 64'(ra) : 64'(0));
      chk("tcm_read_size", 64'(bus_tcm_stbuf_read_size), rok ? 64'(rs) : 64'(0));
      chk("tcm_wr", 64'(bus_tcm_stbuf_wr), 64'(wok));
      chk("tcm_write_addr", 64'(bus_tcm_stbuf_write_addr), wok ? 64'(wa) : 64'(0));
      chk("tcm_write_size", 64'(bus_tcm_stbuf_write_size), wok ? 64'(ws) : 64'(0));
      chk("tcm_write_data", 64'(bus_tcm_stbuf_data), wok ? 64'(unsigned'(wd)) : 64'(0));
      chk("core_rsp_valid", 64'(core_rsp_valid), 64'(rsp_src == 0));
      chk("dbg_rsp_valid", 64'(dbg_rsp_valid), 64'(rsp_src == 1));
      if (rsp_src >= 0) chk("rsp_data", 64'(rsp_data), 64'(tcm_bus_stbuf_data));
      if (err_q.size() > 0) begin
        e = err_q.pop_front();
        chk("err_valid", 64'(err_valid), 64'(1));
        chk("err_src", 64'(err_src), 64'(e.src));
        chk("err_is_wr", 64'(err_is_wr), 64'(e.is_wr));
      end else begin
        chk("err_valid", 64'(err_valid), 64'(0));
      end
      rsp_src = rok ? ((rw == 2) ? 1 : 0) : -1;
      if (!dbg_rd_valid || rw == 2) starve_rd = 0;
      else if (starve_rd < LIMIT) starve_rd++;
      if (!dbg_wr_valid || ww == 2) starve_wr = 0;
      else if (starve_wr < LIMIT) starve_wr++;
      if (rw != 0 && !rok) err_q.push_back('{src: (rw == 2) ? 1 : 0, is_wr: 0});
      if (ww != 0 && !wok) err_q.push_back('{src: (ww == 2) ? 1 : 0, is_wr: 1});
      g_crd = (rw == 1); g_drd = (rw == 2); g_cwr = (ww == 1); g_dwr = (ww == 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    core_rd_valid = 0; dbg_rd_valid = 0; core_wr_valid = 0; dbg_wr_valid = 0;
  endtask

  function automatic bit any_held_bad();
    return (core_rd_valid && !legal(int'(core_rd_addr), int'(core_rd_size))) ||
           (dbg_rd_valid  && !legal(int'(dbg_rd_addr),  int'(dbg_rd_size)))  ||
           (core_wr_valid && !legal(int'(core_wr_addr), int'(core_wr_size))) ||
           (dbg_wr_valid  && !legal(int'(dbg_wr_addr),  int'(dbg_wr_size)));
  endfunction

  // Illegal requests only when no error is outstanding, so at most one error is ever in flight.
  task automatic new_req(output logic v, output logic [AW-1:0] a, output logic [SW-1:0] s, output logic [RW-1:0] d);
    int k, sz, ad;
    bit allow_bad;
    allow_bad = (err_q.size() == 0) && !any_held_bad();
    v = $urandom_range(0, 2) != 0;
    k = $urandom_range(0, 2);
    sz = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    ad = $urandom_range(0, TSZ - 4);
    if ($urandom_range(0, 9) == 0) ad = TSZ - sz;
    if (v && allow_bad && $urandom_range(0, 7) == 0) begin
      if ($urandom_range(0, 1) == 1) sz = ($urandom_range(0, 1) == 1) ? 3 : 0;
      else begin sz = 4; ad = TSZ - $urandom_range(1, 3); end
    end
    a = AW'(ad);
    s = SW'(sz);
    d = RW'($urandom);
  endtask

  initial begin
    rst = 1;
    idle_all();
    core_rd_addr = '0; core_rd_size = '0; dbg_rd_addr = '0; dbg_rd_size = '0;
    core_wr_addr = '0; core_wr_size = '0; core_wr_data = '0;
    dbg_wr_addr = '0; dbg_wr_size = '0; dbg_wr_data = '0;
    tcm_bus_stbuf_data = '0;
    step(); step();
    rst = 0;
    step();

    core_rd_valid = 1; core_rd_addr = 16'h0010; core_rd_size = 3'd4;
    step();
    idle_all();
    step();

    core_rd_valid = 1; dbg_rd_valid = 1; core_rd_addr = 16'h0100; dbg_rd_addr = 16'h0200;
    core_rd_size = 3'd4; dbg_rd_size = 3'd2;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("starve_pattern_dbg_grant", 64'(obs_drd), 64'(i == 4 || i == 9));
    end
    idle_all();
    step();

    core_rd_valid = 1; core_rd_addr = 16'h0020; core_rd_size = 3'd4;
    dbg_wr_valid = 1; dbg_wr_addr = 16'h0040; dbg_wr_size = 3'd2; dbg_wr_data = 32'h0000_BEEF;
    step();
    idle_all();
    step();

    dbg_wr_valid = 1; dbg_wr_addr = 16'h0080; dbg_wr_size = 3'd3;
    step();
    idle_all();
    step();

    core_rd_valid = 1; core_rd_addr = AW'(TSZ - 2); core_rd_size = 3'd4;
    step();
    idle_all();
    step(); step();

    core_rd_valid = 1; core_rd_addr = AW'(TSZ - 4); core_rd_size = 3'd4;
    step();
    idle_all();
    step();

    core_rd_valid = 1; core_rd_addr = 16'h0004; core_rd_size = 3'd0;
    dbg_wr_valid = 1; dbg_wr_addr = AW'(TSZ - 1); dbg_wr_size = 3'd2;
    step();
    idle_all();
    step(); step(); step();

    core_rd_valid = 1; core_rd_addr = 16'h0030; core_rd_size = 3'd1;
    dbg_rd_valid = 1; dbg_rd_addr = 16'h0034; dbg_rd_size = 3'd1;
    step(); step();
    rst = 1;
    step();
    rst = 0;
    idle_all();
    step();
    dbg_rd_valid = 1; core_rd_valid = 1;
    step();
    chk("post_rst_core_first", 64'(obs_drd), 64'(0));
    idle_all();
    step();

    for (int n = 0; n < 600; n++) begin
      if (!core_rd_valid || g_crd) new_req(core_rd_valid, core_rd_addr, core_rd_size, core_wr_data);
      if (!dbg_rd_valid  || g_drd) new_req(dbg_rd_valid,  dbg_rd_addr,  dbg_rd_size,  dbg_wr_data);
      if (!core_wr_valid || g_cwr) new_req(core_wr_valid, core_wr_addr, core_wr_size, core_wr_data);
      if (!dbg_wr_valid  || g_dwr) new_req(dbg_wr_valid,  dbg_wr_addr,  dbg_wr_size,  dbg_wr_data);
      step();
    end
    idle_all();
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
